puf_challenge_gen: RTL and testbench

//  Parametrised successor to the PUF challenge generator: builds N_CB-bit challenges N_RNG bits/beat

---
 rtl/puf_challenge_gen_pkg.sv | 26 ++
 rtl/puf_challenge_gen_if.sv | 11 +
 rtl/puf_challenge_gen_lfsr.sv | 40 ++++
 rtl/puf_challenge_gen_trng_ro.sv | 48 ++++
 rtl/puf_challenge_gen.sv | 118 +++++++++++
 tb/tb_puf_challenge_gen.sv | 370 +++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/puf_challenge_gen_pkg.sv
// Shared types and constants for the PUF challenge generator and its LFSR.
package chal_gen_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } chal_state_e;

  localparam logic MODE_TRNG = 1'b0;
  localparam logic MODE_LFSR = 1'b1;

  localparam logic [31:0] LFSR_DEFAULT = 32'hACE1_2468;
  // x^32 + x^22 + x^2 + x + 1 : feedback from bits 31, 21, 1, 0
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

  // Maximal-length tap masks for the supported widths; others fall back to the 32-bit mask.
  function automatic logic [63:0] lfsr_taps(input int unsigned w);
    case (w)
      8:       lfsr_taps = 64'h0000_0000_0000_00B8;
      16:      lfsr_taps = 64'h0000_0000_0000_D008;
      64:      lfsr_taps = 64'hD800_0000_0000_0000;
      default: lfsr_taps = {32'h0, LFSR_TAPS_32};
    endcase
  endfunction

endpackage

// File: rtl/puf_challenge_gen_if.sv
// Challenge handoff bundle between the generator (master) and the PUF controller (slave).
interface puf_challenge_gen_if #(
  parameter int unsigned N_CB = 64
);
  logic            c_valid;
  logic            c_ready;
  logic [N_CB-1:0] C;

  modport master (output c_valid, output C, input c_ready);
  modport slave  (input c_valid, input C, output c_ready);
endinterface

// File: rtl/puf_challenge_gen_lfsr.sv
// Seedable Fibonacci LFSR; exposes its low OUT_W state bits and never enters the all-zero state.
module chal_lfsr
  import chal_gen_pkg::*;
#(
  parameter int unsigned LFSR_W = 32,
  parameter int unsigned OUT_W  = LFSR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  output logic [OUT_W-1:0]  state
);

  localparam logic [LFSR_W-1:0] TAPS    = LFSR_W'(lfsr_taps(LFSR_W));
  localparam logic [LFSR_W-1:0] DEF_VAL = LFSR_W'(LFSR_DEFAULT);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = (seed == '0) ? DEF_VAL : seed;
    end else if (step) begin
      lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= DEF_VAL;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/puf_challenge_gen_trng_ro.sv
// Ring-oscillator TRNG cell: RO_N rings of 2*RO_n+1 stages XOR-combined and sampled on clk.
// Rings are modelled as clocked Johnson loops that each idle on a different phase so they drift apart.
module TRNG_RO #(
  parameter int unsigned RO_n    = 3,
  parameter int unsigned RO_N    = 16,
  parameter int unsigned RO_LOGN = 4,
  parameter logic [31:0] SALT    = 32'h0
) (
  input  logic clk,
  input  logic rst_n,
  output logic rnd
);

  localparam int unsigned L = 2 * RO_n + 1;

  logic [RO_N-1:0][L-1:0] ring_q, ring_d;
  logic [RO_LOGN-1:0]     div_q, div_d;
  logic                   rnd_q, rnd_d;

  always_comb begin
    ring_d = ring_q;
    div_d  = div_q + 1'b1;
    rnd_d  = 1'b0;
    for (int unsigned i = 0; i < RO_N; i++) begin
      if (div_q != RO_LOGN'(i)) begin
        ring_d[i] = {ring_q[i][L-2:0], ~ring_q[i][L-1]};
      end
      rnd_d = rnd_d ^ ring_q[i][0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RO_N; i++) begin
        ring_q[i] <= L'(SALT * 32'd7 + i * 32'd5);
      end
      div_q <= '0;
      rnd_q <= 1'b0;
    end else begin
      ring_q <= ring_d;
      div_q  <= div_d;
      rnd_q  <= rnd_d;
    end
  end

  assign rnd = rnd_q;

endmodule

// File: rtl/puf_challenge_gen.sv
// PUF challenge generator: fills N_CB-bit challenges N_RNG bits per beat from TRNGs or an LFSR.
// Optional CHAL_WHITEN_EN: XOR the LFSR into TRNG data and advance it on TRNG beats as well.
module puf_challenge_gen
  import chal_gen_pkg::*;
#(
  parameter int unsigned N_CB    = 64,
  parameter int unsigned N_RNG   = 8,
  parameter int unsigned RO_n    = 3,
  parameter int unsigned RO_N    = 16,
  parameter int unsigned RO_LOGN = 4,
  parameter int unsigned LFSR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic               seed_load,
  input  logic [LFSR_W-1:0]  seed,
  puf_challenge_gen_if.master chal
);

  localparam int unsigned BEATS = N_CB / N_RNG;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  chal_state_e      state_q, state_d;
  logic [N_CB-1:0]  c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;

  logic [N_RNG-1:0] rand_bits;
  logic [N_RNG-1:0] lfsr_lo;
  logic [N_RNG-1:0] src;
  logic             lfsr_step;
  logic             restart;

  for (genvar g = 0; g < N_RNG; g++) begin : g_trng
    TRNG_RO #(
      .RO_n   (RO_n),
      .RO_N   (RO_N),
      .RO_LOGN(RO_LOGN),
      .SALT   (32'(g))
    ) u_trng (
      .clk  (clk),
      .rst_n(rst),
      .rnd  (rand_bits[g])
    );
  end

  chal_lfsr #(
    .LFSR_W(LFSR_W),
    .OUT_W (N_RNG)
  ) u_lfsr (
    .clk  (clk),
    .rst_n(rst),
    .step (lfsr_step),
    .load (seed_load),
    .seed (seed),
    .state(lfsr_lo)
  );

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    mode_d  = mode;
`ifdef CHAL_WHITEN_EN
    src       = (mode == MODE_LFSR) ? lfsr_lo : (rand_bits ^ lfsr_lo);
    lfsr_step = (state_q == FILL) && en;
`else
    src       = (mode == MODE_LFSR) ? lfsr_lo : rand_bits;
    lfsr_step = (state_q == FILL) && en && (mode == MODE_LFSR);
`endif
    // A source switch or reseed discards the partial fill so no challenge mixes sources.
    restart = (mode != mode_q) || (seed_load && (mode == MODE_LFSR));

    case (state_q)
      FILL: begin
        if (en) begin
          c_d = N_CB'({src, c_q} >> N_RNG);
          if (cnt_q == CNT_W'(BEATS - 1)) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        if (restart) begin
          cnt_d   = '0;
          state_d = FILL;
        end
      end
      HOLD: begin
        if (chal.c_ready) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
      c_q     <= '0;
      cnt_q   <= '0;
      mode_q  <= MODE_TRNG;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  assign chal.c_valid = (state_q == HOLD);
  assign chal.C       = c_q;

endmodule

// File: tb/tb_puf_challenge_gen.sv
// Self-checking bench for puf_challenge_gen (N_CB=64, N_RNG=8) against a sequence-level reference model.
module tb_puf_challenge_gen;

  localparam int unsigned N_CB  = 64;
  localparam int unsigned N_RNG = 8;
  localparam int unsigned LW    = 32;
  localparam logic [31:0] DEF_SEED = 32'hACE1_2468;
  localparam logic [31:0] TAP_MASK = (32'd1 << 31) | (32'd1 << 21) | (32'd1 << 1) | 32'd1;
`ifdef CHAL_WHITEN_EN
  localparam int unsigned WHITEN = 1;
`else
  localparam int unsigned WHITEN = 0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            mode;
  logic            seed_load;
  logic [LW-1:0]   seed;

  int unsigned checks = 0;
  int unsigned errors = 0;

  puf_challenge_gen_if #(.N_CB(N_CB)) cif ();

  puf_challenge_gen #(
    .N_CB   (N_CB),
    .N_RNG  (N_RNG),
    .RO_n   (3),
    .RO_N   (16),
    .RO_LOGN(4),
    .LFSR_W (LW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .seed_load(seed_load),
    .seed     (seed),
    .chal     (cif)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_step(input logic [31:0] s);
    int unsigned fb;
    fb = $countones(s & TAP_MASK) % 2;
    return (s << 1) | 32'(fb);
  endfunction

  function automatic logic [31:0] ref_adv(input logic [31:0] s, input int unsigned n);
    logic [31:0] t;
    t = s;
    for (int unsigned k = 0; k < n; k++) t = ref_step(t);
    return t;
  endfunction

  function automatic logic [31:0] ref_seed(input logic [31:0] s);
    return (s == 32'h0) ? DEF_SEED : s;
  endfunction

  // Challenge built from 8 consecutive LFSR states; first beat lands in the lowest byte.
  function automatic logic [63:0] ref_chal(input logic [31:0] s, input logic [7:0] xr);
    logic [63:0] c;
    logic [31:0] t;
    c = '0;
    t = s;
    for (int unsigned k = 0; k < 8; k++) begin
      c[k*8 +: 8] = t[7:0] ^ xr;
      t = ref_step(t);
    end
    return c;
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept();
    en          = 1'b0;
    cif.c_ready = 1'b1;
    tick();
    cif.c_ready = 1'b0;
  endtask

  task automatic prep_lfsr(input logic [31:0] s);
    if (cif.c_valid === 1'b1) accept();
    mode      = 1'b1;
    en        = 1'b0;
    seed      = s;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
  endtask

  task automatic run_fill(input int unsigned limit, output int unsigned edges);
    edges = 0;
    en    = 1'b1;
    while (cif.c_valid !== 1'b1 && edges < limit) begin
      tick();
      edges++;
    end
    en = 1'b0;
  endtask

  logic [63:0] c1;

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; en = 1'b0; mode = 1'b0; seed_load = 1'b0; seed = '0; cif.c_ready = 1'b0;
    tick(); tick();
    checks++;
    if (cif.c_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", cif.c_valid);
    end
    checks++;
    if (cif.C !== 64'h0) begin
      errors++; $display("FAIL reset_C: got %h expected 0", cif.C);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_lfsr_fill();
    int unsigned e;
    prep_lfsr(32'h1);
    run_fill(30, e);
    c1 = ref_chal(32'h1, 8'h00);
    checks++;
    if (e !== 8) begin
      errors++; $display("FAIL lfsr_latency: got %0d beats expected 8", e);
    end
    checks++;
    if (cif.C !== c1) begin
      errors++; $display("FAIL lfsr_chal: got %h expected %h", cif.C, c1);
    end
    for (int i = 0; i < 20; i++) begin
      en = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (cif.C !== c1 || cif.c_valid !== 1'b1) begin
        errors++; $display("FAIL hold_stable[%0d]: got %h/%b expected %h/1", i, cif.C, cif.c_valid, c1);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_handoff();
    int unsigned beats;
    int unsigned cyc;
    logic [63:0] exp_c;
    exp_c = ref_chal(ref_adv(32'h1, 8), 8'h00);
    en = 1'b1;
    cif.c_ready = 1'b1;
    tick();
    cif.c_ready = 1'b0;
    checks++;
    if (cif.c_valid !== 1'b0) begin
      errors++; $display("FAIL handoff_drop: got %b expected 0", cif.c_valid);
    end
    beats = 0;
    cyc   = 0;
    while (beats < 8 && cyc < 200) begin
      en          = 1'($urandom_range(0, 1));
      cif.c_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
      if (en) beats++;
      checks++;
      if (cif.c_valid !== (beats == 8)) begin
        errors++; $display("FAIL rand_en_valid: got %b expected %b at beat %0d", cif.c_valid, beats == 8, beats);
      end
    end
    en = 1'b0;
    cif.c_ready = 1'b0;
    checks++;
    if (cif.C !== exp_c) begin
      errors++; $display("FAIL second_chal: got %h expected %h", cif.C, exp_c);
    end
    checks++;
    if (cif.C === c1) begin
      errors++; $display("FAIL second_differs: got %h expected anything but %h", cif.C, c1);
    end
  endtask

  task automatic test_en_toggle();
    int unsigned edges;
    logic [31:0] r, r2;
    logic [63:0] held;
    prep_lfsr(32'h1);
    edges = 0;
    while (cif.c_valid !== 1'b1 && edges < 40) begin
      en = edges[0];
      tick();
      edges++;
    end
    en = 1'b0;
    checks++;
    if (edges !== 16) begin
      errors++; $display("FAIL toggle_latency: got %0d cycles expected 16", edges);
    end
    checks++;
    if (cif.C !== c1) begin
      errors++; $display("FAIL toggle_chal: got %h expected %h", cif.C, c1);
    end
    prep_lfsr(32'h0);
    run_fill(30, edges);
    checks++;
    if (cif.C !== ref_chal(DEF_SEED, 8'h00)) begin
      errors++; $display("FAIL zero_seed: got %h expected %h", cif.C, ref_chal(DEF_SEED, 8'h00));
    end
    prep_lfsr(DEF_SEED);
    run_fill(30, edges);
    checks++;
    if (cif.C !== ref_chal(DEF_SEED, 8'h00)) begin
      errors++; $display("FAIL default_seed: got %h expected %h", cif.C, ref_chal(DEF_SEED, 8'h00));
    end
    r = $urandom();
    prep_lfsr(r);
    run_fill(30, edges);
    held = cif.C;
    checks++;
    if (held !== ref_chal(ref_seed(r), 8'h00)) begin
      errors++; $display("FAIL rand_seed: got %h expected %h", held, ref_chal(ref_seed(r), 8'h00));
    end
    r2 = $urandom();
    seed = r2;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    tick();
    checks++;
    if (cif.C !== ref_chal(ref_seed(r), 8'h00) || cif.c_valid !== 1'b1) begin
      errors++; $display("FAIL hold_seed_load: got %h/%b expected %h/1", cif.C, cif.c_valid, ref_chal(ref_seed(r), 8'h00));
    end
    accept();
    run_fill(30, edges);
    checks++;
    if (cif.C !== ref_chal(ref_seed(r2), 8'h00)) begin
      errors++; $display("FAIL reseed_in_hold: got %h expected %h", cif.C, ref_chal(ref_seed(r2), 8'h00));
    end
  endtask

  task automatic test_mode_flip();
    int unsigned edges;
    logic [31:0] s, t;
    s = $urandom();
    prep_lfsr(s);
    mode = 1'b0;
    en   = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    mode = 1'b1;
    run_fill(40, edges);
    checks++;
    if (edges !== 9) begin
      errors++; $display("FAIL flip_latency: got %0d beats expected 9", edges);
    end
    checks++;
    if (cif.C !== ref_chal(ref_adv(ref_seed(s), 4 * WHITEN + 1), 8'h00)) begin
      errors++; $display("FAIL flip_chal: got %h expected %h", cif.C, ref_chal(ref_adv(ref_seed(s), 4 * WHITEN + 1), 8'h00));
    end
    // reseed on the same cycle as a beat
    accept();
    en = 1'b1;
    tick(); tick(); tick();
    t = $urandom();
    seed = t;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    run_fill(30, edges);
    checks++;
    if (edges !== 8) begin
      errors++; $display("FAIL collide_latency: got %0d beats expected 8", edges);
    end
    checks++;
    if (cif.C !== ref_chal(ref_seed(t), 8'h00)) begin
      errors++; $display("FAIL collide_chal: got %h expected %h", cif.C, ref_chal(ref_seed(t), 8'h00));
    end
  endtask

  task automatic test_reset_async();
    int unsigned edges;
    prep_lfsr($urandom() | 32'h1);
    en = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    #2;
    checks++;
    if (cif.C !== 64'h0) begin
      errors++; $display("FAIL async_rst_C: got %h expected 0", cif.C);
    end
    checks++;
    if (cif.c_valid !== 1'b0) begin
      errors++; $display("FAIL async_rst_valid: got %b expected 0", cif.c_valid);
    end
    en = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    run_fill(30, edges);
    checks++;
    if (edges !== 8 || cif.C !== ref_chal(DEF_SEED, 8'h00)) begin
      errors++; $display("FAIL post_rst_fill: got %0d/%h expected 8/%h", edges, cif.C, ref_chal(DEF_SEED, 8'h00));
    end
  endtask

  task automatic test_trng();
    int unsigned edges;
    logic [31:0] s;
    logic [7:0]  r8;
    logic [63:0] exp_c;
    accept();
    s = $urandom();
    mode = 1'b0;
    seed = s;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
`ifdef CHAL_WHITEN_EN
    force dut.rand_bits = 8'h00;
    exp_c = ref_chal(ref_seed(s), 8'h00);
`else
    force dut.rand_bits = 8'hFF;
    exp_c = 64'hFFFF_FFFF_FFFF_FFFF;
`endif
    run_fill(30, edges);
    checks++;
    if (edges !== 8 || cif.C !== exp_c) begin
      errors++; $display("FAIL trng_fixed: got %0d/%h expected 8/%h", edges, cif.C, exp_c);
    end
    r8 = 8'($urandom());
    force dut.rand_bits = r8;
    accept();
`ifdef CHAL_WHITEN_EN
    exp_c = ref_chal(ref_adv(ref_seed(s), 8), r8);
`else
    exp_c = {8{r8}};
`endif
    run_fill(30, edges);
    checks++;
    if (cif.C !== exp_c) begin
      errors++; $display("FAIL trng_pattern: got %h expected %h", cif.C, exp_c);
    end
    release dut.rand_bits;
  endtask

  initial begin
    test_reset();
    test_lfsr_fill();
    test_handoff();
    test_en_toggle();
    test_mode_flip();
    test_reset_async();
    test_trng();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
